// File: rtl/ext_sinal_pipe_pkg.sv
// Shared definitions for the pipelined immediate extender: mode encodings and
// the packed layout of one buffered result.
package ext_sinal_pkg;

  localparam logic [1:0] EXT_BAIXO  = 2'b00;  // sign/zero extend into low bits
  localparam logic [1:0] EXT_ALTO   = 2'b01;  // place immediate in upper bits
  localparam logic [1:0] EXT_DESLOC = 2'b10;  // extend then shift (branch offset)
  localparam logic [1:0] EXT_INVAL  = 2'b11;  // reserved, flagged as error

  typedef logic [1:0] op_ext_t;

  // Buffer entry for the default 32-bit datapath; the top builds the same
  // {erro, saida} packing at its own OUT_W.
  typedef struct packed {
    logic        erro;
    logic [31:0] saida;
  } ext_entry_t;

  function automatic logic op_is_legal(input op_ext_t op);
    return (op != EXT_INVAL);
  endfunction

endpackage

// File: rtl/ext_sinal_pipe_if.sv
// Request/result handshake bundle between decode, the extender and the ALU side.
interface ext_sinal_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  import ext_sinal_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  entrada;
  op_ext_t          OpExt;
  logic             Negativo;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] saida;
  logic             erro;

  // Upstream decode and downstream consumer view.
  modport master (
    output in_valid, entrada, OpExt, Negativo, out_ready,
    input  in_ready, out_valid, saida, erro
  );

  // Extender view.
  modport slave (
    input  in_valid, entrada, OpExt, Negativo, out_ready,
    output in_ready, out_valid, saida, erro
  );
endinterface

// File: rtl/ext_sinal_pipe_core.sv
// Combinational immediate extender: low extend, upper placement, extend+shift,
// and an error flag for the reserved mode.
module ext_sinal_core
  import ext_sinal_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int SHIFT_AMT = 2
) (
  input  logic [IN_W-1:0]  entrada,
  input  op_ext_t          OpExt,
  input  logic             Negativo,
  output logic [OUT_W-1:0] saida,
  output logic             erro
);

  generate
    if (OUT_W < IN_W + SHIFT_AMT) begin : g_bad_widths
      $error("ext_sinal_core: OUT_W must be >= IN_W + SHIFT_AMT");
    end
  endgenerate

  logic             fill;
  logic [OUT_W-1:0] ext_baixo;

  assign fill = entrada[IN_W-1] & Negativo;

  // Select the extended value for the requested mode; reserved mode yields 0 + erro.
  always_comb begin
    ext_baixo               = {OUT_W{fill}};
    ext_baixo[IN_W-1:0]     = entrada;
    saida                   = '0;
    erro                    = 1'b0;
    case (OpExt)
      EXT_BAIXO:  saida = ext_baixo;
      EXT_ALTO:   saida = OUT_W'(entrada) << (OUT_W - IN_W);
      // Shifting drops only fill copies from the top since OUT_W >= IN_W + SHIFT_AMT.
      EXT_DESLOC: saida = ext_baixo << SHIFT_AMT;
      default:    erro  = ~op_is_legal(OpExt);
    endcase
  end

endmodule

// File: rtl/ext_sinal_pipe.sv
// Pipelined immediate extender: output register plus one skid entry so that
// in_ready is registered and never depends combinationally on out_ready.
module ext_sinal_pipe
  import ext_sinal_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int SHIFT_AMT = 2
) (
  input logic               clock,
  input logic               reset,
  ext_sinal_pipe_if.slave   bus
);

  typedef struct packed {
    logic             erro;
    logic [OUT_W-1:0] saida;
  } entry_t;

  entry_t core_res;
  entry_t out_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   skid_valid_q;
  logic   accept;
  logic   out_free;

  ext_sinal_core #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .SHIFT_AMT (SHIFT_AMT)
  ) u_core (
    .entrada  (bus.entrada),
    .OpExt    (bus.OpExt),
    .Negativo (bus.Negativo),
    .saida    (core_res.saida),
    .erro     (core_res.erro)
  );

  assign accept   = bus.in_valid & ~skid_valid_q;
  assign out_free = ~out_valid_q | bus.out_ready;

  // Output reg takes the skid entry first (FIFO order), else the new request;
  // a request arriving while the output is stalled parks in the skid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q        <= core_res;
        out_valid_q  <= 1'b1;
      end else begin
        out_valid_q  <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= core_res;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready  = ~skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.saida     = out_q.saida;
  assign bus.erro      = out_q.erro;

endmodule
